// File: rtl/axis_drain_pkg.sv
// Shared constants and helpers for the result drain path.
// Lane geometry of a 32-bit beat plus a pointer-width helper.
package axis_drain_pkg;

  localparam int LANE_W         = 5;
  localparam int LANES_PER_BEAT = 6;
  localparam int BEAT_PAD       = 2;
  localparam int BEAT_W         =
    LANE_W * LANES_PER_BEAT + BEAT_PAD;

  function automatic int clogb2(input int value);
    int n;
    n = 0;
    for (int i = 0; i < 31; i++) begin
      if ((value >> i) != 0) n = i + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/axis_beat_reg.sv
// AXI-Stream output register: holds tdata/tlast stable
// while tvalid is up until the sink takes the beat.
module axis_beat_reg
  import axis_drain_pkg::*;
#(
  parameter int W = BEAT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] tdata_d,
  input  logic         tlast_d,
  input  logic         tready,
  output logic         ready,
  output logic [W-1:0] tdata,
  output logic         tvalid,
  output logic         tlast
);

  assign ready = ~tvalid | tready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tdata  <= '0;
      tvalid <= 1'b0;
      tlast  <= 1'b0;
    end else if (clear) begin
      tvalid <= 1'b0;
      tlast  <= 1'b0;
    end else if (load) begin
      tdata  <= tdata_d;
      tvalid <= 1'b1;
      tlast  <= tlast_d;
    end else if (tready) begin
      tvalid <= 1'b0;
      tlast  <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_result_drain.sv
// MAC result FIFO + 6-lanes-per-beat AXI-Stream serializer.
// Define AXIS_DRAIN_TLAST_EN to drive tlast on each vector's last beat.
module axis_result_drain
  import axis_drain_pkg::*;
#(
  parameter int C_M_AXIS_TDATA_WIDTH  = 32,
  parameter int MAC_NUM               = 256,
  parameter int AXIS_DRAIN_FIFO_DEPTH = 4,
  parameter int bit_num = clogb2(AXIS_DRAIN_FIFO_DEPTH - 1)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [LANE_W*MAC_NUM-1:0]       ofmaps_in,
  input  logic                            push_result,
  input  logic [11:0]                     output_channel_size,
  input  logic                            axis_clear,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  output logic [bit_num:0]                fifo_cnt,
  output logic                            fifo_empty,
  output logic                            fifo_full,
  output logic                            drain_busy
);

  localparam int VEC_W = LANE_W * MAC_NUM;

  logic [VEC_W-1:0] mem [AXIS_DRAIN_FIFO_DEPTH];
  logic [bit_num-1:0] wr_ptr;
  logic [bit_num-1:0] rd_ptr;
  logic [11:0] lane_cnt;
  logic [12:0] lane_end;
  logic [VEC_W-1:0] shifted;
  logic [C_M_AXIS_TDATA_WIDTH-1:0] beat_d;
  logic ready, load, last, pop, write_en, tlast_d;

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  =
    (fifo_cnt == (bit_num+1)'(AXIS_DRAIN_FIFO_DEPTH));
  assign drain_busy = ~fifo_empty | m_axis_tvalid;

  assign load     = ready & ~fifo_empty;
  assign lane_end = {1'b0, lane_cnt} + 13'd6;
  assign last     = lane_end >= {1'b0, output_channel_size};
  assign pop      = load & last;
  assign write_en = push_result & (~fifo_full | pop);

  assign shifted = mem[rd_ptr] >> (lane_cnt * LANE_W);

  // Lanes past the channel count or the array width read as zero
  always_comb begin
    beat_d = '0;
    for (int j = 0; j < LANES_PER_BEAT; j++) begin
      if ((32'(lane_cnt) + 32'(j)) < 32'(output_channel_size) &&
          (32'(lane_cnt) + 32'(j)) < 32'(MAC_NUM))
        beat_d[j*LANE_W +: LANE_W] = shifted[j*LANE_W +: LANE_W];
    end
  end

`ifdef AXIS_DRAIN_TLAST_EN
  assign tlast_d = last;
`else
  assign tlast_d = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (write_en && !axis_clear) mem[wr_ptr] <= ofmaps_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      lane_cnt <= '0;
    end else if (axis_clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      lane_cnt <= '0;
    end else begin
      if (write_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (load) lane_cnt <= last ? 12'd0 : lane_cnt + 12'd6;
      unique case (1'b1)
        write_en & ~pop: fifo_cnt <= fifo_cnt + 1'b1;
        pop & ~write_en: fifo_cnt <= fifo_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  axis_beat_reg #(
    .W(C_M_AXIS_TDATA_WIDTH)
  ) u_beat (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (axis_clear),
    .load   (load),
    .tdata_d(beat_d),
    .tlast_d(tlast_d),
    .tready (m_axis_tready),
    .ready  (ready),
    .tdata  (m_axis_tdata),
    .tvalid (m_axis_tvalid),
    .tlast  (m_axis_tlast)
  );

endmodule

// File: tb/tb_axis_result_drain.sv
// Bench for axis_result_drain: vector table, corner sequences,
// and random backpressure against a beat-queue reference model.
module tb_axis_result_drain;

`ifdef AXIS_DRAIN_TLAST_EN
  localparam logic TLAST_EN = 1'b1;
`else
  localparam logic TLAST_EN = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic [1279:0] ofmaps_in;
  logic          push_result;
  logic [11:0]   output_channel_size;
  logic          axis_clear;
  logic [31:0]   m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic [2:0]    fifo_cnt;
  logic          fifo_empty;
  logic          fifo_full;
  logic          drain_busy;

  axis_result_drain dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .ofmaps_in          (ofmaps_in),
    .push_result        (push_result),
    .output_channel_size(output_channel_size),
    .axis_clear         (axis_clear),
    .m_axis_tdata       (m_axis_tdata),
    .m_axis_tvalid      (m_axis_tvalid),
    .m_axis_tready      (m_axis_tready),
    .m_axis_tlast       (m_axis_tlast),
    .fifo_cnt           (fifo_cnt),
    .fifo_empty         (fifo_empty),
    .fifo_full          (fifo_full),
    .drain_busy         (drain_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          size;
    int          beats;
    logic [31:0] first;
    logic [31:0] lastd;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic        l;
    logic        e;
  } beat_t;

  int n_cmp = 0;
  int n_err = 0;
  beat_t expq[$];
  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference beat: lanes base..base+5, zero beyond size / 256
  function automatic logic [31:0] beat_of(input logic [1279:0] v,
                                          input int base,
                                          input int size);
    logic [31:0] d;
    d = '0;
    for (int j = 0; j < 6; j++)
      if (base + j < size && base + j < 256)
        d[5*j +: 5] = v[5*(base+j) +: 5];
    return d;
  endfunction

  function automatic logic [1279:0] mod32_vec();
    logic [1279:0] v;
    for (int k = 0; k < 256; k++) v[5*k +: 5] = 5'(k % 32);
    return v;
  endfunction

  function automatic logic [1279:0] rand_vec();
    logic [1279:0] v;
    for (int k = 0; k < 256; k++) v[5*k +: 5] = 5'($urandom);
    return v;
  endfunction

  task automatic model_push(input logic [1279:0] v, input int size);
    int nb;
    beat_t b;
    nb = (size + 5) / 6;
    for (int i = 0; i < nb; i++) begin
      b.d = beat_of(v, 6 * i, size);
      b.e = (i == nb - 1);
      b.l = TLAST_EN & b.e;
      expq.push_back(b);
    end
  endtask

  task automatic run_vec(input string tag, input logic [1279:0] v,
                         input vec_t r);
    int nb, tl, first_at;
    logic [31:0] fd, ld;
    logic ll;
    bit done;
    @(negedge clk);
    ofmaps_in = v;
    output_channel_size = 12'(r.size);
    push_result = 1'b1;
    m_axis_tready = 1'b1;
    @(negedge clk);
    push_result = 1'b0;
    chk({tag, "_pre_tvalid"}, 32'(m_axis_tvalid), 32'd0);
    chk({tag, "_pre_cnt"}, 32'(fifo_cnt), 32'd1);
    nb = 0; tl = 0; first_at = -1; done = 0;
    fd = '0; ld = '0; ll = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (m_axis_tvalid) begin
        if (nb == 0) begin
          fd = m_axis_tdata;
          first_at = c;
        end
        ld = m_axis_tdata;
        ll = m_axis_tlast;
        tl += int'(m_axis_tlast);
        nb++;
      end else if (nb > 0) begin
        done = 1;
      end
    end
    chk({tag, "_latency"}, 32'(first_at), 32'd0);
    chk({tag, "_beats"}, 32'(nb), 32'(r.beats));
    chk({tag, "_first"}, fd, r.first);
    chk({tag, "_last"}, ld, r.lastd);
    chk({tag, "_tlast_end"}, 32'(ll), 32'(TLAST_EN));
    chk({tag, "_tlast_cnt"}, 32'(tl), 32'(TLAST_EN));
    chk({tag, "_idle"}, 32'(drain_busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1279:0] vf[7];
    logic [31:0] fexp[6];
    int fcnt[6];
    logic [1279:0] va, vb;
    logic pv, pr, pl;
    logic [31:0] pd;
    int bound, seen, nvec;
    bit stop;
    beat_t b;

    tbl[0] = '{256, 43, 32'h0A418820, 32'h000FFBBC};
    tbl[1] = '{255, 43, 32'h0A418820, 32'h00007BBC};
    tbl[2] = '{100, 17, 32'h0A418820, 32'h00018820};
    tbl[3] = '{12,  2,  32'h0A418820, 32'h16A4A0E6};
    tbl[4] = '{7,   2,  32'h0A418820, 32'h00000006};
    tbl[5] = '{6,   1,  32'h0A418820, 32'h0A418820};
    tbl[6] = '{5,   1,  32'h00418820, 32'h00418820};

    rst_n = 1'b0;
    ofmaps_in = '0;
    push_result = 1'b0;
    output_channel_size = 12'd256;
    axis_clear = 1'b0;
    m_axis_tready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_tdata", m_axis_tdata, 32'd0);
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_tlast", 32'(m_axis_tlast), 32'd0);
    chk("rst_cnt", 32'(fifo_cnt), 32'd0);
    chk("rst_empty", 32'(fifo_empty), 32'd1);
    chk("rst_full", 32'(fifo_full), 32'd0);
    chk("rst_busy", 32'(drain_busy), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++)
      run_vec($sformatf("row%0d", i), mod32_vec(), tbl[i]);

    // Fill with tready low: one vector sits in the output
    // register, four in the FIFO, the sixth push is dropped.
    output_channel_size = 12'd6;
    m_axis_tready = 1'b0;
    for (int i = 0; i < 7; i++) vf[i] = rand_vec();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ofmaps_in = vf[i];
      push_result = 1'b1;
    end
    for (int i = 0; i < 5; i++) fexp[i] = beat_of(vf[i], 0, 6);
    fexp[5] = beat_of(vf[6], 0, 6);
    fcnt = '{4, 4, 3, 2, 1, 0};
    @(negedge clk);
    chk("full_cnt", 32'(fifo_cnt), 32'd4);
    chk("full_flag", 32'(fifo_full), 32'd1);
    ofmaps_in = vf[6];
    push_result = 1'b1;
    m_axis_tready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin
        @(negedge clk);
        push_result = 1'b0;
      end
      chk($sformatf("full_valid%0d", k), 32'(m_axis_tvalid), 32'd1);
      chk($sformatf("full_data%0d", k), m_axis_tdata, fexp[k]);
      chk($sformatf("full_tlast%0d", k), 32'(m_axis_tlast),
          32'(TLAST_EN));
      if (k > 0) begin
        chk($sformatf("full_cnt%0d", k), 32'(fifo_cnt), 32'(fcnt[k]));
        chk($sformatf("full_flag%0d", k), 32'(fifo_full),
            32'(k == 1));
      end
    end
    @(negedge clk);
    chk("full_done_valid", 32'(m_axis_tvalid), 32'd0);
    chk("full_done_empty", 32'(fifo_empty), 32'd1);

    // Random backpressure against the beat queue model
    output_channel_size = 12'd100;
    pv = 0; pr = 0; pl = 0; pd = '0;
    bound = 0; nvec = 0; stop = 0;
    for (int cyc = 0; cyc < 4000 && !stop; cyc++) begin
      @(negedge clk);
      if (pv && pr) begin
        if (expq.size() == 0) begin
          chk("rnd_extra_beat", pd, 32'hDEAD_BEEF);
        end else begin
          b = expq.pop_front();
          chk("rnd_data", pd, b.d);
          chk("rnd_tlast", 32'(pl), 32'(b.l));
          if (b.e) bound--;
        end
      end
      if (pv && !pr) begin
        chk("rnd_hold_valid", 32'(m_axis_tvalid), 32'd1);
        chk("rnd_hold_data", m_axis_tdata, pd);
        chk("rnd_hold_tlast", 32'(m_axis_tlast), 32'(pl));
      end
      pv = m_axis_tvalid;
      pd = m_axis_tdata;
      pl = m_axis_tlast;
      push_result = 1'b0;
      if (cyc < 800) begin
        if (bound < 4 && $urandom_range(0, 3) == 0) begin
          va = rand_vec();
          ofmaps_in = va;
          push_result = 1'b1;
          model_push(va, 100);
          bound++;
          nvec++;
        end
        m_axis_tready = 1'($urandom_range(0, 1));
      end else begin
        m_axis_tready = 1'b1;
        if (expq.size() == 0 && !m_axis_tvalid) stop = 1;
      end
      pr = m_axis_tready;
    end
    chk("rnd_drained", 32'(expq.size()), 32'd0);
    chk("rnd_idle", 32'(drain_busy), 32'd0);
    if (nvec == 0) chk("rnd_nvec", 32'(nvec), 32'd1);

    // Abort mid-vector, then check a new vector starts at lane 0
    output_channel_size = 12'd256;
    va = rand_vec();
    vb = rand_vec();
    m_axis_tready = 1'b1;
    @(negedge clk);
    ofmaps_in = va;
    push_result = 1'b1;
    @(negedge clk);
    ofmaps_in = vb;
    @(negedge clk);
    push_result = 1'b0;
    seen = 0;
    for (int c = 0; c < 100 && seen < 10; c++) begin
      if (m_axis_tvalid) begin
        chk($sformatf("clr_beat%0d", seen), m_axis_tdata,
            beat_of(va, 6 * seen, 256));
        seen++;
      end
      if (seen < 10) @(negedge clk);
    end
    chk("clr_seen", 32'(seen), 32'd10);
    axis_clear = 1'b1;
    @(negedge clk);
    axis_clear = 1'b0;
    chk("clr_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("clr_tlast", 32'(m_axis_tlast), 32'd0);
    chk("clr_cnt", 32'(fifo_cnt), 32'd0);
    chk("clr_empty", 32'(fifo_empty), 32'd1);
    va = rand_vec();
    run_vec("clr_after", va,
            '{12, 2, beat_of(va, 0, 12), beat_of(va, 6, 12)});

    // Asynchronous reset in the middle of a vector
    va = rand_vec();
    output_channel_size = 12'd256;
    @(negedge clk);
    ofmaps_in = va;
    push_result = 1'b1;
    @(negedge clk);
    push_result = 1'b0;
    repeat (5) @(negedge clk);
    chk("ar_pre_valid", 32'(m_axis_tvalid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_tdata", m_axis_tdata, 32'd0);
    chk("ar_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("ar_tlast", 32'(m_axis_tlast), 32'd0);
    chk("ar_cnt", 32'(fifo_cnt), 32'd0);
    chk("ar_empty", 32'(fifo_empty), 32'd1);
    chk("ar_full", 32'(fifo_full), 32'd0);
    chk("ar_busy", 32'(drain_busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec("ar_after", mod32_vec(), tbl[3]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
